// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues req/ack reads to
// instruction memory and presents {pc+step, instruction} to the IF/ID
// register through a 1-entry output buffer backed by a 1-entry skid buffer.
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);

    // REQ : request outstanding at pc_q
    // KILL: wrong-path request still in flight at kill_addr_q, data dropped
    // SKID: output buffer frozen and skid full, no request issued
    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_KILL = 2'd1;
    localparam logic [1:0] ST_SKID = 2'd2;

    logic [1:0]  state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] kill_addr_q,  kill_addr_d;
    logic        ob_valid_q,   ob_valid_d;
    logic [31:0] ob_pc_q,      ob_pc_d;
    logic [31:0] ob_instr_q,   ob_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic        consume;
    logic        accept;
    logic [31:0] pc_next;

    assign consume = ob_valid_q && !freeze;
    assign accept  = !ob_valid_q || consume;
    assign pc_next = pc_q + PC_STEP;

    // Next-state logic for the fetch FSM, PC and both buffers.
    always_comb begin
        // NOTE: every target gets a hold value first so no path leaves one unassigned (no latch).
        state_d      = state_q;
        pc_d         = pc_q;
        kill_addr_d  = kill_addr_q;
        ob_valid_d   = ob_valid_q && !consume;
        ob_pc_d      = ob_pc_q;
        ob_instr_d   = ob_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        // Word arriving with the redirect is wrong-path: drop it.
                        pc_d       = branch_addr;
                        ob_valid_d = 1'b0;
                    end else if (accept) begin
                        ob_valid_d = 1'b1;
                        ob_pc_d    = pc_next;
                        ob_instr_d = imem_rdata;
                        pc_d       = pc_next;
                    end else begin
                        skid_pc_d    = pc_next;
                        skid_instr_d = imem_rdata;
                        pc_d         = pc_next;
                        state_d      = ST_SKID;
                    end
                end else if (branch_taken) begin
                    // The in-flight read cannot be aborted; remember its address
                    // so imem_addr stays stable until it completes.
                    kill_addr_d = pc_q;
                    pc_d        = branch_addr;
                    ob_valid_d  = 1'b0;
                    state_d     = ST_KILL;
                end
            end
            ST_KILL: begin
                if (branch_taken) begin
                    pc_d = branch_addr;
                end
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            ST_SKID: begin
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    ob_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end else if (consume) begin
                    ob_valid_d = 1'b1;
                    ob_pc_d    = skid_pc_q;
                    ob_instr_d = skid_instr_q;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                state_d    = ST_REQ;
                ob_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= PC_RESET;
            kill_addr_q  <= PC_RESET;
            ob_valid_q   <= 1'b0;
            ob_pc_q      <= 32'h0;
            ob_instr_q   <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_addr_q  <= kill_addr_d;
            ob_valid_q   <= ob_valid_d;
            ob_pc_q      <= ob_pc_d;
            ob_instr_q   <= ob_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    // Memory request and bubble-gated outputs; all quiet while reset is held.
    always_comb begin
        imem_req        = !rst && (state_q == ST_REQ || state_q == ST_KILL);
        imem_addr       = (state_q == ST_KILL) ? kill_addr_q : pc_q;
        fetch_valid     = !rst && ob_valid_q;
        pc_out          = fetch_valid ? ob_pc_q    : 32'h0;
        instruction_out = fetch_valid ? ob_instr_q : 32'h0;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a per-cycle vector table covering
// reset, wait states, freeze/skid, redirects and PC wrap, followed by a
// hand-written freeze-toggling run checked against an in-order PC scoreboard.
module tb_if_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;

    int err_cnt = 0;
    int chk_cnt = 0;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .fetch_valid     (fetch_valid)
    );

    always #5 clk = ~clk;

    // One row per cycle: inputs held for that cycle and outputs expected
    // during it, before the closing rising edge.
    typedef struct {
        logic        rst;
        logic        frz;
        logic        br;
        logic [31:0] br_addr;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                       input logic a, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.frz = f; v.br = b; v.br_addr = ba; v.ack = a;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e_instr;
        logic [23:0] pat;
        logic [31:0] exp_pc;
        int          n_cons;

        //   rst frz br br_addr         ack req addr            vld pc
        // 1: zero-wait, back-to-back fetches
        add(1, 0, 0, 32'h0,           0,  0, 32'h0,           0, 32'h0);
        add(1, 0, 0, 32'h0,           0,  0, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h4,           1, 32'h4);
        add(0, 0, 0, 32'h0,           1,  1, 32'h8,           1, 32'h8);
        add(0, 0, 0, 32'h0,           0,  1, 32'hC,           1, 32'hC);
        // 2: two wait states
        add(1, 0, 0, 32'h0,           0,  0, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h4,           1, 32'h4);
        // 3: freeze three cycles after first valid, skid fills
        add(1, 0, 0, 32'h0,           0,  0, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h0,           0, 32'h0);
        add(0, 1, 0, 32'h0,           1,  1, 32'h4,           1, 32'h4);
        add(0, 1, 0, 32'h0,           0,  0, 32'h8,           1, 32'h4);
        add(0, 1, 0, 32'h0,           0,  0, 32'h8,           1, 32'h4);
        add(0, 0, 0, 32'h0,           0,  0, 32'h8,           1, 32'h4);
        add(0, 0, 0, 32'h0,           1,  1, 32'h8,           1, 32'h8);
        add(0, 0, 0, 32'h0,           0,  1, 32'hC,           1, 32'hC);
        // 4: redirect while addr 8 waits
        add(1, 0, 0, 32'h0,           0,  0, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h4,           1, 32'h4);
        add(0, 0, 0, 32'h0,           0,  1, 32'h8,           1, 32'h8);
        add(0, 0, 0, 32'h0,           0,  1, 32'h8,           0, 32'h0);
        add(0, 0, 1, 32'h100,         0,  1, 32'h8,           0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h8,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h8,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h100,         0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h104,         1, 32'h104);
        // 5a: redirect on the ack edge
        add(0, 0, 1, 32'h200,         1,  1, 32'h104,         0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h200,         0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h204,         1, 32'h204);
        // 5b: redirect while frozen with skid full
        add(0, 0, 0, 32'h0,           1,  1, 32'h204,         0, 32'h0);
        add(0, 1, 0, 32'h0,           1,  1, 32'h208,         1, 32'h208);
        add(0, 1, 1, 32'h300,         0,  0, 32'h20C,         1, 32'h208);
        add(0, 1, 0, 32'h0,           0,  1, 32'h300,         0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h300,         0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h304,         1, 32'h304);
        // second redirect while a killed read is still in flight
        add(0, 0, 1, 32'h400,         0,  1, 32'h304,         0, 32'h0);
        add(0, 0, 1, 32'h500,         0,  1, 32'h304,         0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h304,         0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h500,         0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h504,         1, 32'h504);
        // 6: reset mid-wait at 0xC
        add(1, 0, 0, 32'h0,           0,  0, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h4,           1, 32'h4);
        add(0, 0, 0, 32'h0,           1,  1, 32'h8,           1, 32'h8);
        add(0, 0, 0, 32'h0,           0,  1, 32'hC,           1, 32'hC);
        add(0, 0, 0, 32'h0,           0,  1, 32'hC,           0, 32'h0);
        add(1, 0, 0, 32'h0,           0,  0, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'h0,           0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h4,           1, 32'h4);
        // PC wrap: 0xFFFFFFFC + 4 -> 0
        add(0, 0, 1, 32'hFFFF_FFFC,   1,  1, 32'h4,           0, 32'h0);
        add(0, 0, 0, 32'h0,           1,  1, 32'hFFFF_FFFC,   0, 32'h0);
        add(0, 0, 0, 32'h0,           0,  1, 32'h0,           1, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            freeze       = vecs[i].frz;
            branch_taken = vecs[i].br;
            branch_addr  = vecs[i].br_addr;
            imem_ack     = vecs[i].ack;
            imem_rdata   = vecs[i].ack ? (vecs[i].e_addr ^ K) : 32'hDEAD_BEEF;
            #1;
            e_instr = vecs[i].e_valid ? ((vecs[i].e_pc - 32'd4) ^ K) : 32'h0;
            check($sformatf("v%0d imem_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            if (vecs[i].e_req)
                check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d fetch_valid", i), {31'h0, fetch_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_pc);
            check($sformatf("v%0d instruction_out", i), instruction_out, e_instr);
        end

        // Zero-wait memory with freeze toggling: every consumed entry must
        // follow the previous one by exactly PC_STEP (no loss, no repeat).
        @(negedge clk);
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        pat    = 24'b0011_0100_0111_0000_1001_0100;
        exp_pc = 32'h4;
        n_cons = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rst    = 1'b0;
            freeze = pat[c];
            #1;
            imem_ack   = imem_req;
            imem_rdata = imem_addr ^ K;
            #1;
            if (fetch_valid && !freeze) begin
                check($sformatf("seq%0d pc_out", c), pc_out, exp_pc);
                check($sformatf("seq%0d instruction_out", c), instruction_out, (exp_pc - 32'd4) ^ K);
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
        end
        check("seq consumed_at_least_13", {31'h0, (n_cons >= 13)}, 32'h1);

        @(negedge clk);
        imem_ack = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
